// File: rtl/sync_trigger_sequencer.sv
// Firing sequencer: waits for the selected fast-gate window, aligns to a phase
// edge inside it, emits one trigger pulse and grades the wire-sensor acknowledge.
module sync_trigger_sequencer #(
   parameter int CNT_W        = 32,
   parameter int GATE_SKIP    = 1,
   parameter int PHASE_DELAY  = 0,
   parameter int TRIG_WIDTH   = 10,
   parameter int GATE_TIMEOUT = 2_000_000,
   parameter int ACK_MIN      = 400_000,
   parameter int ACK_TIMEOUT  = 1_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_condition,
   input  logic       abort,
   input  logic       fast_gate,
   input  logic       phase_signal,
   input  logic       wire_sensor,
   output logic       output_trigger,
   output logic       busy,
   output logic       done,
   output logic [2:0] status,
   output logic [7:0] gate_count
);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ARM        = 3'd1;
   localparam logic [2:0] ST_WAIT_PHASE = 3'd2;
   localparam logic [2:0] ST_DELAY      = 3'd3;
   localparam logic [2:0] ST_FIRE       = 3'd4;
   localparam logic [2:0] ST_WAIT_ACK   = 3'd5;
   localparam logic [2:0] ST_FAULT      = 3'd6;
   localparam logic [2:0] ST_END        = 3'd7;

   localparam logic [2:0] STAT_NONE      = 3'd0;
   localparam logic [2:0] STAT_OK        = 3'd1;
   localparam logic [2:0] STAT_GATE_TO   = 3'd2;
   localparam logic [2:0] STAT_WIN_MISS  = 3'd3;
   localparam logic [2:0] STAT_ACK_TO    = 3'd4;
   localparam logic [2:0] STAT_ACK_EARLY = 3'd5;
   localparam logic [2:0] STAT_ABORTED   = 3'd6;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] GATE_TO_C = CNT_W'(GATE_TIMEOUT);
   localparam logic [CNT_W-1:0] PD_LAST_C = CNT_W'((PHASE_DELAY > 0) ? PHASE_DELAY - 1 : 0);
   localparam logic [CNT_W-1:0] TW_LAST_C = CNT_W'(TRIG_WIDTH - 1);
   localparam logic [CNT_W-1:0] ACK_MIN_C = CNT_W'(ACK_MIN);
   localparam logic [CNT_W-1:0] ACK_TO_C  = CNT_W'(ACK_TIMEOUT);
   localparam logic [7:0]       SKIP_C    = 8'(GATE_SKIP);

   // Bits [1:0] are the synchroniser, bit [2] is the previous value for edge detect.
   logic [2:0] start_sync, gate_sync, phase_sync, wire_sync;
   logic       start_rise, gate_rise, gate_hi, phase_rise, wire_rise;

   logic [2:0]       state;
   logic [2:0]       fault_code;
   logic [CNT_W-1:0] cnt;
   logic             early;

   // NOTE: all clocked state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_sync <= '0;
         gate_sync  <= '0;
         phase_sync <= '0;
         wire_sync  <= '0;
      end else begin
         start_sync <= {start_sync[1:0], start_condition};
         gate_sync  <= {gate_sync[1:0],  fast_gate};
         phase_sync <= {phase_sync[1:0], phase_signal};
         wire_sync  <= {wire_sync[1:0],  wire_sensor};
      end
   end

   assign start_rise = start_sync[1] & ~start_sync[2];
   assign gate_rise  = gate_sync[1]  & ~gate_sync[2];
   assign gate_hi    = gate_sync[1];
   assign phase_rise = phase_sync[1] & ~phase_sync[2];
   assign wire_rise  = wire_sync[1]  & ~wire_sync[2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         fault_code     <= STAT_NONE;
         cnt            <= '0;
         early          <= 1'b0;
         output_trigger <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         status         <= STAT_NONE;
         gate_count     <= '0;
      end else begin
         done <= 1'b0;
         if (abort && (state != ST_IDLE)) begin
            state          <= ST_IDLE;
            output_trigger <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b1;
            status         <= STAT_ABORTED;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_rise) begin
                     state      <= ST_ARM;
                     busy       <= 1'b1;
                     status     <= STAT_NONE;
                     gate_count <= '0;
                     cnt        <= '0;
                     early      <= 1'b0;
                  end
               end
               ST_ARM: begin
                  if (gate_rise) begin
                     cnt <= '0;
                     if (gate_count != 8'hFF) gate_count <= gate_count + 8'd1;
                     if (gate_count == SKIP_C) state <= ST_WAIT_PHASE;
                  end else if (cnt == GATE_TO_C) begin
                     fault_code <= STAT_GATE_TO;
                     state      <= ST_FAULT;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               ST_WAIT_PHASE: begin
                  // A phase edge in the same cycle as the gate fall still fires.
                  if (phase_rise) begin
                     cnt <= '0;
                     if (PHASE_DELAY > 0) begin
                        state <= ST_DELAY;
                     end else begin
                        state          <= ST_FIRE;
                        output_trigger <= 1'b1;
                     end
                  end else if (!gate_hi) begin
                     fault_code <= STAT_WIN_MISS;
                     state      <= ST_FAULT;
                  end
               end
               ST_DELAY: begin
                  if (cnt == PD_LAST_C) begin
                     state          <= ST_FIRE;
                     output_trigger <= 1'b1;
                     cnt            <= '0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               ST_FIRE: begin
                  // cnt doubles as the ack counter from the trigger rise onward.
                  cnt <= cnt + CNT_ONE;
                  if (wire_rise) early <= 1'b1;
                  if (cnt == TW_LAST_C) begin
                     output_trigger <= 1'b0;
                     if (early || wire_rise) begin
                        fault_code <= STAT_ACK_EARLY;
                        state      <= ST_FAULT;
                     end else begin
                        state <= ST_WAIT_ACK;
                     end
                  end
               end
               ST_WAIT_ACK: begin
                  if (wire_rise) begin
                     if (cnt < ACK_MIN_C) begin
                        fault_code <= STAT_ACK_EARLY;
                        state      <= ST_FAULT;
                     end else begin
                        state <= ST_END;
                     end
                  end else if (cnt == ACK_TO_C) begin
                     fault_code <= STAT_ACK_TO;
                     state      <= ST_FAULT;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               ST_FAULT: begin
                  status <= fault_code;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end
               ST_END: begin
                  status <= STAT_OK;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
